somador_sequencial: RTL and testbench

//  Parametrised multi-cycle adder/subtractor; successor of the 4-bit ripple adder.

---
 rtl/somador_sequencial_if.sv | 27 ++
 rtl/somador_sequencial.sv | 105 ++++++++++
 tb/tb_somador_sequencial.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/somador_sequencial_if.sv
// Handshake and operand/result bundle for the
// multi-cycle adder/subtractor.
interface somador_sequencial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, a, b, c_in,
    input  ready, busy, done, out, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output ready, busy, done, out, c_out, ovf
  );
endinterface

// File: rtl/somador_sequencial.sv
// Multi-cycle adder/subtractor: CHUNK bits per
// clock, LSB slice first, carry kept between slices.
module somador_sequencial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  somador_sequencial_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] out_q;
  logic             c_out_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   sum;
  logic             msb_cin;
  logic             last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Current slice sum and carry into the MSB
  always_comb begin
    a_sl    = a_q[idx_q*CHUNK +: CHUNK];
    b_sl    = b_q[idx_q*CHUNK +: CHUNK];
    sum     = {1'b0, a_sl} + {1'b0, b_sl}
            + {{CHUNK{1'b0}}, carry_q};
    msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1]
            ^ sum[CHUNK-1];
    last    = (idx_q == IW'(NCHUNK - 1));
  end

  // Operand capture and slice-wise accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.c_in;
            out_q   <= '0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          out_q[idx_q*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
          carry_q <= sum[CHUNK];
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            c_out_q <= sum[CHUNK];
            ovf_q   <= msb_cin ^ sum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.out   = out_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_somador_sequencial.sv
// Directed bench: 8/4 with hand vectors, plus
// 16/4 and 8/8 against an arithmetic model.
module tb_somador_sequencial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  somador_sequencial_if #(.WIDTH(8))  i0 ();
  somador_sequencial_if #(.WIDTH(16)) i1 ();
  somador_sequencial_if #(.WIDTH(8))  i2 ();

  somador_sequencial #(.WIDTH(8), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .bus(i0)
  );
  somador_sequencial #(.WIDTH(16), .CHUNK(4)) u1 (
    .clk(clk), .rst(rst), .bus(i1)
  );
  somador_sequencial #(.WIDTH(8), .CHUNK(8)) u2 (
    .clk(clk), .rst(rst), .bus(i2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int u,
                        input logic st,
                        input logic s,
                        input logic [15:0] x,
                        input logic [15:0] y,
                        input logic ci);
    case (u)
      0: begin
        i0.start = st; i0.sub = s;
        i0.a = x[7:0]; i0.b = y[7:0]; i0.c_in = ci;
      end
      1: begin
        i1.start = st; i1.sub = s;
        i1.a = x; i1.b = y; i1.c_in = ci;
      end
      default: begin
        i2.start = st; i2.sub = s;
        i2.a = x[7:0]; i2.b = y[7:0]; i2.c_in = ci;
      end
    endcase
  endtask

  function automatic logic [2:0] flags(input int u);
    case (u)
      0: return {i0.ready, i0.busy, i0.done};
      1: return {i1.ready, i1.busy, i1.done};
      default: return {i2.ready, i2.busy, i2.done};
    endcase
  endfunction

  function automatic logic [17:0] res(input int u);
    case (u)
      0: return {i0.c_out, i0.ovf, 8'h00, i0.out};
      1: return {i1.c_out, i1.ovf, i1.out};
      default: return {i2.c_out, i2.ovf, 8'h00, i2.out};
    endcase
  endfunction

  function automatic int nch(input int u);
    return (u == 1) ? 4 : ((u == 2) ? 1 : 2);
  endfunction

  function automatic logic [17:0] model(input int u,
                                        input logic s,
                                        input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic ci);
    int w, mask, xa, bb, t, o, sa, sb, so;
    logic c, v;
    w    = (u == 1) ? 16 : 8;
    mask = (1 << w) - 1;
    xa   = int'(x) & mask;
    bb   = (s ? ~int'(y) : int'(y)) & mask;
    t    = xa + bb + (s ? 1 : int'(ci));
    o    = t & mask;
    c    = ((t >> w) & 1) != 0;
    sa   = (xa >> (w - 1)) & 1;
    sb   = (bb >> (w - 1)) & 1;
    so   = (o >> (w - 1)) & 1;
    v    = (sa == sb) && (so != sa);
    return {c, v, o[15:0]};
  endfunction

  task automatic op(input int u,
                    input logic s,
                    input logic [15:0] x,
                    input logic [15:0] y,
                    input logic ci,
                    input logic [17:0] exp,
                    input string tag);
    int n;
    chk({tag, "/rdy"}, 32'(flags(u)), 32'h4);
    set_in(u, 1'b1, s, x, y, ci);
    tick();
    set_in(u, 1'b0, ~s, ~x, y + 16'h55, ~ci);
    n = 0;
    while (flags(u)[0] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "/lat"}, 32'(n), 32'(nch(u)));
    chk({tag, "/res"}, 32'(res(u)), 32'(exp));
    tick();
    chk({tag, "/idle"}, 32'(flags(u)), 32'h4);
    chk({tag, "/hold"}, 32'(res(u)), 32'(exp));
  endtask

  typedef struct {
    logic        s;
    logic [15:0] x;
    logic [15:0] y;
    logic        ci;
  } vec_t;

  initial begin
    int n;
    vec_t tv[$];
    for (int u = 0; u < 3; u++)
      set_in(u, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst%0d/flg", u),
          32'(flags(u)), 32'h4);
      chk($sformatf("rst%0d/res", u),
          32'(res(u)), 32'h0);
    end

    op(0, 0, 10,  6,   0, {2'b00, 16'd16},  "add10_6");
    op(0, 0, 200, 100, 0, {2'b10, 16'd44},  "add200_100");
    op(0, 0, 127, 1,   0, {2'b01, 16'd128}, "add127_1");
    op(0, 1, 5,   7,   0, {2'b00, 16'd254}, "sub5_7");
    op(0, 1, 9,   2,   1, {2'b10, 16'd7},   "sub9_2");
    op(0, 0, 255, 0,   1, {2'b10, 16'd0},   "add255_ci");
    op(0, 1, 128, 1,   0, {2'b11, 16'd127}, "sub128_1");

    set_in(0, 1'b1, 1'b0, 16'd10, 16'd6, 1'b0);
    chk("hold/s0", 32'(flags(0)), 32'h4);
    tick();
    chk("hold/s1", 32'(flags(0)), 32'h2);
    set_in(0, 1'b1, 1'b1, 16'd1, 16'd1, 1'b1);
    tick();
    chk("hold/s2", 32'(flags(0)), 32'h2);
    set_in(0, 1'b1, 1'b0, 16'd2, 16'd9, 1'b0);
    tick();
    chk("hold/s3", 32'(flags(0)), 32'h1);
    chk("hold/r1", 32'(res(0)), 32'd16);
    set_in(0, 1'b1, 1'b0, 16'd3, 16'd4, 1'b0);
    tick();
    chk("hold/s4", 32'(flags(0)), 32'h4);
    tick();
    chk("hold/s5", 32'(flags(0)), 32'h2);
    set_in(0, 1'b1, 1'b1, 16'd99, 16'd99, 1'b1);
    tick();
    chk("hold/s6", 32'(flags(0)), 32'h2);
    tick();
    chk("hold/s7", 32'(flags(0)), 32'h1);
    chk("hold/r2", 32'(res(0)), 32'd7);
    set_in(0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    tick();
    chk("hold/s8", 32'(flags(0)), 32'h4);

    set_in(1, 1'b1, 1'b0, 16'h1234, 16'h1111, 1'b0);
    tick();
    set_in(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    chk("mrst/busy", 32'(flags(1)), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst/flg", 32'(flags(1)), 32'h4);
    chk("mrst/res", 32'(res(1)), 32'h0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (flags(1)[0] === 1'b1) n++;
      tick();
    end
    chk("mrst/nodone", 32'(n), 32'h0);

    tv.push_back('{1'b0, 16'd10,    16'd6,    1'b0});
    tv.push_back('{1'b0, 16'd200,   16'd100,  1'b0});
    tv.push_back('{1'b0, 16'd127,   16'd1,    1'b0});
    tv.push_back('{1'b1, 16'd5,     16'd7,    1'b0});
    tv.push_back('{1'b1, 16'd9,     16'd2,    1'b1});
    tv.push_back('{1'b0, 16'hFFFF,  16'h0,    1'b1});
    tv.push_back('{1'b0, 16'h7FFF,  16'h0001, 1'b0});
    tv.push_back('{1'b0, 16'hBEEF,  16'hCAFE, 1'b1});
    tv.push_back('{1'b1, 16'h8000,  16'h0001, 1'b0});
    for (int u = 1; u < 3; u++) begin
      foreach (tv[i]) begin
        op(u, tv[i].s, tv[i].x, tv[i].y, tv[i].ci,
           model(u, tv[i].s, tv[i].x, tv[i].y, tv[i].ci),
           $sformatf("m%0d_%0d", u, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
